// File: rtl/opcode_encoder.sv
// Debounced push-button front end producing one held 3-bit opcode per accepted press.
// Define OPCODE_ENC_DEBOUNCE_EN to enable per-button debounce counters (otherwise a single register stage).
module opcode_encoder #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_number,
   input  logic       btn_enter,
   input  logic [3:0] btn_op,
   output logic [2:0] opcode,
   output logic       valid,
   output logic       busy,
   output logic       overrun
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_EMIT    = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   // Bit order: [0] number, [1] enter, [5:2] operators 0..3
   logic [5:0] raw;
   logic [5:0] sync1_q, sync2_q;
   logic [5:0] level_q, level_d;
   logic [5:0] press;

   assign raw = {btn_op, btn_enter, btn_number};

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
      end
   end

`ifdef OPCODE_ENC_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_deb
         logic [DW-1:0] cnt_q, cnt_d;
         logic          lvl_d;

         // The level flips on the edge after the counter has reached DEBOUNCE_CYCLES.
         always_comb begin
            cnt_d = cnt_q;
            lvl_d = level_q[gi];
            if (sync2_q[gi] == level_q[gi]) begin
               cnt_d = '0;
            end else if (cnt_q == DW'(DEBOUNCE_CYCLES)) begin
               lvl_d = sync2_q[gi];
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (reset) cnt_q <= '0;
            else       cnt_q <= cnt_d;
         end

         assign level_d[gi] = lvl_d;
      end
   endgenerate
`else
   logic unused_debounce;
   assign unused_debounce = ^DEBOUNCE_CYCLES;
   assign level_d         = sync2_q;
`endif

   // Press detection looks at the level being loaded so the FSM reacts on the same edge.
   assign press = level_d & ~level_q;

   logic [1:0]    state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [2:0]    opcode_q, opcode_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          overrun_q, overrun_d;
   logic [2:0]    sel_code;

   always_comb begin
      sel_code = 3'b000;
      if      (press[1]) sel_code = 3'b010;
      else if (press[0]) sel_code = 3'b001;
      else if (press[2]) sel_code = 3'b100;
      else if (press[3]) sel_code = 3'b101;
      else if (press[4]) sel_code = 3'b110;
      else if (press[5]) sel_code = 3'b111;
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      opcode_d  = opcode_q;
      overrun_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|press) begin
               state_d  = S_EMIT;
               opcode_d = sel_code;
               hold_d   = HW'(HOLD_CYCLES);
            end
         end
         S_EMIT: begin
            overrun_d = |press;
            if (hold_q == HW'(1)) begin
               state_d  = S_RELEASE;
               opcode_d = 3'b000;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         S_RELEASE: begin
            overrun_d = |press;
            if (level_q == 6'b0) state_d = S_IDLE;
         end
         default: begin
            state_d  = S_IDLE;
            opcode_d = 3'b000;
         end
      endcase
      valid_d = (state_d == S_EMIT);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         hold_q    <= '0;
         opcode_q  <= 3'b000;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         opcode_q  <= opcode_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign opcode  = opcode_q;
   assign valid   = valid_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_opcode_encoder.sv
// Directed bench for opcode_encoder: expected emissions are queued when buttons are driven
// and checked (code, start edge, hold length) as the DUT produces them.
module tb_opcode_encoder;

   localparam int DEB  = 4;
   localparam int HOLD = 4;
`ifdef OPCODE_ENC_DEBOUNCE_EN
   localparam int LAT = DEB + 3;
`else
   localparam int LAT = 3;
`endif
   localparam int REL = LAT + 1;

   logic       clk;
   logic       reset;
   logic       btn_number;
   logic       btn_enter;
   logic [3:0] btn_op;
   logic [2:0] opcode;
   logic       valid;
   logic       busy;
   logic       overrun;

   opcode_encoder #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_number(btn_number),
      .btn_enter (btn_enter),
      .btn_op    (btn_op),
      .opcode    (opcode),
      .valid     (valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   int         assert_count = 0;
   int         fail_count   = 0;
   int         cyc          = 0;
   int         ov_cnt       = 0;
   bit         in_emit      = 0;
   int         emit_len     = 0;
   logic [2:0] cur_op       = 3'b000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_count++;
      assert (obs === exp) else begin
         fail_count++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic expect_op(input logic [2:0] op, input int at);
      exp_t e;
      e.op  = op;
      e.cyc = at;
      sb.push_back(e);
      $display("cycle %0d: expect opcode %03b at cycle %0d", cyc, op, at);
   endtask

   // Advance one edge, then sample outputs and run the emission monitor.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc++;
      #1;
      if (overrun === 1'b1) ov_cnt++;
      check("valid_vs_opcode", {31'd0, valid}, {31'd0, (opcode != 3'b000)});
      if (valid === 1'b1) begin
         if (!in_emit) begin
            in_emit  = 1;
            emit_len = 1;
            cur_op   = opcode;
            $display("cycle %0d: emission opcode %03b", cyc, opcode);
            check("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("op_code", {29'd0, opcode}, {29'd0, e.op});
               check("op_start_cycle", cyc, e.cyc);
            end
         end else begin
            emit_len++;
            check("op_stable", {29'd0, opcode}, {29'd0, cur_op});
         end
      end else if (in_emit) begin
         in_emit = 0;
         check("hold_len", emit_len, HOLD);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int c;
   int ov_before;

   initial begin
      reset      = 1'b1;
      btn_number = 1'b0;
      btn_enter  = 1'b0;
      btn_op     = 4'b0;
      ticks(3);
      check("rst_opcode", {29'd0, opcode}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      reset = 1'b0;
      ticks(2);

      // Single press of number, then busy timing after release
      c = cyc;
      btn_number = 1'b1;
      expect_op(3'b001, c + LAT);
      ticks(20);
      btn_number = 1'b0;
      ticks(REL - 1);
      check("single_busy_held", {31'd0, busy}, 32'd1);
      tick();
      check("single_busy_drop", {31'd0, busy}, 32'd0);
      check("single_no_overrun", ov_cnt, 32'd0);
      ticks(4);

`ifdef OPCODE_ENC_DEBOUNCE_EN
      // Bounce on enter must not produce an opcode
      btn_enter = 1'b1; ticks(3);
      btn_enter = 1'b0; ticks(2);
      btn_enter = 1'b1; ticks(3);
      btn_enter = 1'b0; ticks(12);
      check("bounce_busy", {31'd0, busy}, 32'd0);
      check("bounce_opcode", {29'd0, opcode}, 32'd0);
`endif
      c = cyc;
      btn_enter = 1'b1;
      expect_op(3'b010, c + LAT);
      ticks(10);
      btn_enter = 1'b0;
      ticks(REL + 4);

      // Simultaneous enter, number, op[2]: enter wins, losers must be released
      ov_before = ov_cnt;
      c = cyc;
      btn_enter  = 1'b1;
      btn_number = 1'b1;
      btn_op[2]  = 1'b1;
      expect_op(3'b010, c + LAT);
      ticks(15);
      btn_enter  = 1'b0;
      btn_number = 1'b0;
      ticks(15);
      check("prio_busy_held", {31'd0, busy}, 32'd1);
      btn_op[2] = 1'b0;
      ticks(REL + 2);
      check("prio_busy_drop", {31'd0, busy}, 32'd0);
      check("prio_no_overrun", ov_cnt - ov_before, 32'd0);

      // Operators in order
      for (int i = 0; i < 4; i++) begin
         logic [2:0] code;
         code = 3'b100 | 3'(i);
         c = cyc;
         btn_op[i] = 1'b1;
         expect_op(code, c + LAT);
         ticks(12);
         btn_op[i] = 1'b0;
         ticks(REL + 4);
      end

      // Overrun: number pressed while op[1] is being emitted
      ov_before = ov_cnt;
      c = cyc;
      btn_op[1] = 1'b1;
      expect_op(3'b101, c + LAT);
      ticks(LAT);
      check("ovr_in_emit", {31'd0, valid}, 32'd1);
      btn_number = 1'b1;
      ticks(15);
      btn_op[1]  = 1'b0;
      btn_number = 1'b0;
      ticks(REL + 6);
      check("ovr_one_pulse", ov_cnt - ov_before, 32'd1);
      check("ovr_idle", {31'd0, busy}, 32'd0);

      // Reset in the second hold cycle; button held through reset re-fires afterwards
      c = cyc;
      btn_number = 1'b1;
      expect_op(3'b001, c + LAT);
      ticks(LAT + 1);
      check("rst_mid_valid_before", {31'd0, valid}, 32'd1);
      reset   = 1'b1;
      in_emit = 0;
      tick();
      check("rst_mid_opcode", {29'd0, opcode}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_valid", {31'd0, valid}, 32'd0);
      ticks(3);
      reset = 1'b0;
      c = cyc;
      expect_op(3'b001, c + LAT);
      ticks(12);
      btn_number = 1'b0;
      ticks(REL + 4);

      check("sb_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/opcode_encoder.md
# opcode_encoder

Front-end producer for the calculator control FSM's 3-bit opcode input. It synchronises and debounces six push-buttons (number-load, enter, four operators) and turns each accepted press into one opcode held for a fixed number of cycles, then returns to idle code 000. The FSM's `opCodeIn` connects directly to `opcode`.

## Interface

- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a button's debounced level changes. Must be ≥1.
- `HOLD_CYCLES`, default 4: number of cycles each emitted opcode stays on `opcode`. Must be ≥1.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `btn_number` in 1: raw asynchronous load-number button.
- `btn_enter` in 1: raw asynchronous enter button.
- `btn_op` in 4: raw asynchronous operator buttons. Index 0..3 map to opcodes 100, 101, 110, 111.
- `opcode` out 3: registered opcode. 000 means idle.
- `valid` out 1: high while `opcode` is non-zero.
- `busy` out 1: high in EMIT and RELEASE.
- `overrun` out 1: one-cycle pulse when a press is discarded.

## Operation

- **Encoding:** number = 001, enter = 010, `btn_op[i]` = 3'b100 | i. Code 000 is never emitted as a press.
- **Input stage:** each button passes through a 2-flop synchroniser, then the debounce stage (see Configuration).
- **Press event:** a rising edge of a debounced level (current level vs. previous-cycle level).
- **FSM states:**
  - IDLE: `opcode` = 000. On any press event, go to EMIT and load `opcode` plus a hold counter set to HOLD_CYCLES.
  - EMIT: `opcode` is held. The counter decrements each cycle. When the counter reaches 1, the next edge clears `opcode` to 000 and moves to RELEASE.
  - RELEASE: `opcode` = 000. Wait until all six debounced levels are 0, then go to IDLE on the next edge.
- **Simultaneous press events in IDLE:** priority is enter > number > `btn_op[0]` > `btn_op[1]` > `btn_op[2]` > `btn_op[3]`. Exactly one opcode is emitted. The losing buttons must still be released in RELEASE before another press is accepted, and they do not pulse `overrun`.
- **Overrun:** a press event that occurs in EMIT or RELEASE is dropped. `overrun` is pulsed for the cycle after that event. Each dropped event produces one pulse.
- **Outputs:** `valid` = (state == EMIT). `busy` = (state != IDLE). All outputs are registered.
- **Reset:**
  - `opcode` = 000, `valid` = 0, `busy` = 0, `overrun` = 0.
  - Synchronisers, debounced levels, previous levels and counters are all cleared.
  - State = IDLE.
  - A button held through reset is seen as a fresh press once it is debounced after reset.
  - Reset asserted mid-EMIT clears `opcode` on that same edge.

## Timing

- **Press latency:** raw button goes high and stays high; E1 is the first edge that samples it.
  - With `OPCODE_ENC_DEBOUNCE_EN`: `opcode` becomes non-zero at edge E(DEBOUNCE_CYCLES+3).
  - Without the macro: `opcode` becomes non-zero at edge E3.
- **Hold:** `opcode` and `valid` stay asserted for exactly HOLD_CYCLES cycles.
- **Throughput:** minimum gap between emissions = HOLD_CYCLES + 1 (one cycle in RELEASE) + the release debounce latency.
- **Counter widths:**
  - Debounce counter: $clog2(DEBOUNCE_CYCLES+1) bits.
  - Hold counter: $clog2(HOLD_CYCLES+1) bits.
  - Neither counter wraps: debounce saturates/clears, hold stops at 1.

## Configuration

- **`OPCODE_ENC_DEBOUNCE_EN` defined:**
  - Each button has a counter that increments while the synchronised level differs from the debounced level.
  - The counter resets to 0 whenever the two levels match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- **`OPCODE_ENC_DEBOUNCE_EN` undefined:**
  - The debounced level is the synchronised output registered once.
  - No counters are instantiated.
  - DEBOUNCE_CYCLES is ignored.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4 and HOLD_CYCLES = 4, with the macro defined unless stated.

- **Single press:** `btn_number` high for 20 cycles, then low → `opcode` = 001 at E7 for exactly 4 cycles. `valid` mirrors it. `busy` drops after the release debounce plus 1 cycle. No `overrun`.
- **Bounce rejection:** `btn_enter` pulses high for 3 cycles, low for 2, then high for 3 → `opcode` stays 000. A subsequent stable 10-cycle hold produces 010.
- **Priority:** `btn_enter`, `btn_number` and `btn_op[2]` asserted on the same cycle → only 010 is emitted. No second opcode appears until all three are released. No `overrun`.
- **Operators:** sequential clean presses of `btn_op[0..3]` → 100, 101, 110, 111 in order, each held 4 cycles.
- **Overrun:** `btn_op[1]` pressed and held; `btn_number` pressed during EMIT → only 101 is emitted. `overrun` pulses once. No 001 appears after release.
- **Reset mid-EMIT, and macro-off variant:**
  - `reset` asserted during the 2nd hold cycle → `opcode` = 000 and `busy` = 0 on the next edge.
  - With the macro undefined, the single-press scenario yields 001 at E3.
